// File: rtl/uart_rx_buf_if.sv
// Output handshake bundle of the UART receive buffer.
//   out_data  : byte at the buffer head
//   out_valid : buffer non-empty, out_data is meaningful
//   out_ready : consumer takes the head byte on a rising edge while out_valid
// master = the receive buffer, slave = the consumer.
interface uart_rx_buf_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/uart_rx_buf.sv
// UART 8N1 receiver with a small receive FIFO.
//   clock      : system clock, all state changes on the rising edge
//   reset      : synchronous, active-high
//   rx         : asynchronous serial line (idle high, LSB first)
//   buf_if     : head-of-FIFO handshake (out_data / out_valid / out_ready)
//   fifo_count : number of bytes currently buffered
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : one-cycle pulse when a completed byte finds the FIFO full
// The receiver never stalls; a completed byte either enters the FIFO or is
// dropped (overrun).
module uart_rx_buf #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rx,
  uart_rx_buf_if.master               buf_if,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        frame_err,
  output logic                        overrun
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  // Counter compare points: mid start bit, then one full bit period.
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic          rx_meta, rx_sync;
  state_t        state;
  logic [15:0]   cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          stop_hold;   // bad stop seen, waiting for line to return high

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          push, pop, full, do_push;

  // Two-flop synchronizer; resets to the idle line level so a reset never
  // looks like a start bit.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, regardless of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // A byte is complete in the cycle the stop bit is sampled high.
  assign push = (state == STOP) && !stop_hold && (cnt == LAST) && rx_sync;

  // Receive FSM.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      stop_hold <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            // Still low at mid-bit: a real start bit. High: a glitch.
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shreg <= {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (stop_hold) begin
            if (rx_sync) begin
              stop_hold <= 1'b0;
              state     <= IDLE;
            end
          end else if (cnt == LAST) begin
            cnt <= '0;
            if (rx_sync) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              stop_hold <= 1'b1;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // FIFO control. When full, a push is only accepted alongside a pop, in
  // which case the slot being vacated is the one written.
  assign full    = (fifo_count == CW'(FIFO_DEPTH));
  assign pop     = buf_if.out_valid && buf_if.out_ready;
  assign do_push = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      overrun <= push && full && !pop;
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; out_data is forced to zero while
  // empty instead, so stale entries are never visible.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  assign buf_if.out_valid = (fifo_count != '0);
  assign buf_if.out_data  = buf_if.out_valid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_uart_rx_buf.sv
// Directed bench for uart_rx_buf at 87 clocks per bit, FIFO depth 4.
// Inputs change 1 time unit after a rising edge; a monitor samples outputs on
// the falling edge and records pops, pulse counts and peak occupancy.
module tb_uart_rx_buf;

  localparam int CPB = 87;

  logic       clock = 1'b0;
  logic       reset;
  logic       rx;
  logic [2:0] fifo_count;
  logic       frame_err;
  logic       overrun;

  uart_rx_buf_if bus ();

  uart_rx_buf #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx         (rx),
    .buf_if     (bus),
    .fifo_count (fifo_count),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] popped[$];
  int         fe_cnt, ov_cnt, valid_cycles;
  logic [2:0] max_count;

  always @(negedge clock) begin
    if (bus.out_valid && bus.out_ready) popped.push_back(bus.out_data);
    if (frame_err)     fe_cnt++;
    if (overrun)       ov_cnt++;
    if (bus.out_valid) valid_cycles++;
    if (fifo_count > max_count) max_count = fifo_count;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic clear_mon();
    popped.delete();
    fe_cnt       = 0;
    ov_cnt       = 0;
    valid_cycles = 0;
    max_count    = '0;
  endtask

  function automatic logic [7:0] get_pop(input int i);
    if (i < popped.size()) return popped[i];
    return 8'hxx;
  endfunction

  // Start bit, 8 data bits LSB first, then the stop level for stop_cycles.
  task automatic send_frame(input logic [7:0] b, input int stop_cycles, input logic stop_level);
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_level;
    tick(stop_cycles);
    rx = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    rx    = 1'b1;
    bus.out_ready = 1'b0;
    clear_mon();
    tick(3);
    reset = 1'b0;

    // Reset state
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_data",  bus.out_data,  8'h00);
    check("rst_count", fifo_count,    3'd0);
    check("rst_ferr",  frame_err,     1'b0);
    check("rst_ovr",   overrun,       1'b0);
    tick(5);

    // Single byte, consumer always ready
    bus.out_ready = 1'b1;
    clear_mon();
    send_frame(8'h55, CPB, 1'b1);
    tick(10);
    check("b55_npop",  popped.size(), 1);
    check("b55_data",  get_pop(0),    8'h55);
    check("b55_vcyc",  valid_cycles,  1);
    check("b55_ferr",  fe_cnt,        0);
    check("b55_ovr",   ov_cnt,        0);

    // Start-bit glitch, then a good frame
    clear_mon();
    rx = 1'b0;
    tick(20);
    rx = 1'b1;
    tick(200);
    check("gl_vcyc",   valid_cycles,  0);
    check("gl_ferr",   fe_cnt,        0);
    send_frame(8'hC3, CPB, 1'b1);
    tick(10);
    check("c3_npop",   popped.size(), 1);
    check("c3_data",   get_pop(0),    8'hC3);

    // Framing error: stop bit low for 200 cycles, then a good frame
    clear_mon();
    send_frame(8'hA3, 200, 1'b0);
    tick(CPB);
    check("fe_pulses", fe_cnt,        1);
    check("fe_maxcnt", max_count,     3'd0);
    check("fe_vcyc",   valid_cycles,  0);
    send_frame(8'h7E, CPB, 1'b1);
    tick(10);
    check("7e_npop",   popped.size(), 1);
    check("7e_data",   get_pop(0),    8'h7E);

    // Overrun: five back-to-back bytes into a 4-deep FIFO
    bus.out_ready = 1'b0;
    clear_mon();
    for (int i = 1; i <= 5; i++) send_frame(8'(i), CPB, 1'b1);
    tick(5);
    check("ov_count",  fifo_count,    3'd4);
    check("ov_pulses", ov_cnt,        1);
    check("ov_maxcnt", max_count,     3'd4);
    bus.out_ready = 1'b1;
    tick(10);
    check("ov_npop",   popped.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ov_pop%0d", i), get_pop(i), 8'(i + 1));
    check("ov_empty",  bus.out_valid, 1'b0);

    // Reset during data bit 3 of 0xFF, with one byte already buffered
    bus.out_ready = 1'b0;
    clear_mon();
    send_frame(8'h5A, CPB, 1'b1);
    tick(5);
    check("mr_pre",    fifo_count,    3'd1);
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(3 * CPB + 40);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("mr_valid",  bus.out_valid, 1'b0);
    check("mr_data",   bus.out_data,  8'h00);
    check("mr_count",  fifo_count,    3'd0);
    check("mr_ferr",   frame_err,     1'b0);
    check("mr_ovr",    overrun,       1'b0);
    clear_mon();
    tick(CPB - 40 + 5 * CPB);
    check("mr_nopush", max_count,     3'd0);
    check("mr_noferr", fe_cnt,        0);
    bus.out_ready = 1'b1;
    send_frame(8'h3C, CPB, 1'b1);
    tick(10);
    check("3c_npop",   popped.size(), 1);
    check("3c_data",   get_pop(0),    8'h3C);

    // Full FIFO with a pop in the exact push cycle of a fifth byte.
    // Push lands on the 830th rising edge after the start bit is driven:
    // 2 synchronizer edges + IDLE edge + 44 to mid-start + 9 bit periods.
    bus.out_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, CPB, 1'b1);
    send_frame(8'h22, CPB, 1'b1);
    send_frame(8'h33, CPB, 1'b1);
    send_frame(8'h44, CPB, 1'b1);
    check("fp_count",  fifo_count,    3'd4);
    fork
      send_frame(8'h99, CPB, 1'b1);
      begin
        tick(829);
        bus.out_ready = 1'b1;
        tick(1);
        bus.out_ready = 1'b0;
      end
    join
    tick(10);
    check("fp_ovr",    ov_cnt,        0);
    check("fp_count2", fifo_count,    3'd4);
    check("fp_pop0",   get_pop(0),    8'h11);
    check("fp_maxcnt", max_count,     3'd4);
    bus.out_ready = 1'b1;
    tick(10);
    check("fp_npop",   popped.size(), 5);
    check("fp_pop1",   get_pop(1),    8'h22);
    check("fp_pop3",   get_pop(3),    8'h44);
    check("fp_last",   get_pop(4),    8'h99);
    check("fp_empty",  bus.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf.md
UART_RX_BUF -- requirements
Module: uart_rx_buf

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, clock cycles per UART bit (10 MHz system clock / 115200 baud); legal range 8..65535.
REQ-002 Parameter FIFO_DEPTH, default 4, receive buffer entries; legal values are powers of two, 2..64.
REQ-003 clock  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1 framing, LSB first.
REQ-006 out_data  output  8  byte at the FIFO head.
REQ-007 out_valid  output  1  FIFO non-empty; out_data is valid.
REQ-008 out_ready  input  1  consumer accepts the head byte.
REQ-009 fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes currently buffered.
REQ-010 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 overrun  output  1  one-cycle pulse: completed byte dropped because the FIFO was full.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer before any use; synchronizer flops reset to 1.
REQ-013 The receive FSM SHALL have four states: IDLE, START, DATA, STOP.
- IDLE->START: synchronized rx == 0; bit counter cleared.
REQ-014 In START, the synchronized rx SHALL be sampled when the bit counter reaches (CLKS_PER_BIT-1)/2.
- rx == 0: go to DATA; counter restarts.
- rx == 1: glitch; return to IDLE with no output.
REQ-015 In DATA, rx SHALL be sampled every CLKS_PER_BIT cycles from the mid-start point.
- 8 samples, shifted in LSB first.
- Go to STOP after the 8th sample.
REQ-016 In STOP, rx SHALL be sampled CLKS_PER_BIT cycles after the 8th data sample.
- rx == 1: push the byte into the FIFO; go to IDLE.
- rx == 0: pulse frame_err for one cycle, discard the byte, hold in STOP until synchronized rx == 1, then go to IDLE.
REQ-017 A push SHALL occur in the stop-sample cycle; out_valid (when the FIFO was empty) and fifo_count SHALL update on the next rising edge.
REQ-018 out_valid SHALL equal (fifo_count != 0).
- Transfer occurs when out_valid && out_ready at a rising edge.
- out_data SHALL hold stable while out_valid && !out_ready.
REQ-019 FIFO full (fifo_count == FIFO_DEPTH) with push and no pop: the byte SHALL be dropped, overrun SHALL pulse one cycle, and FIFO contents SHALL be unchanged.
REQ-020 FIFO full with simultaneous push and pop: both SHALL occur, fifo_count SHALL stay at FIFO_DEPTH, and no overrun.
REQ-021 Push and pop in the same cycle when not full: fifo_count SHALL be unchanged and ordering SHALL remain FIFO.
REQ-022 out_ready while empty SHALL have no effect.
REQ-023 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.
REQ-024 Back-to-back frames SHALL be received with no idle time between the stop bit and the next start bit.
REQ-025 Receiver operation SHALL be independent of out_ready; the FSM never stalls.

Reset
REQ-026 While reset is high at a rising edge, the block SHALL enter these values: FSM IDLE, counters 0, shift register 0, pointers 0, fifo_count 0, out_valid 0, frame_err 0, overrun 0.
REQ-027 out_data SHALL be 0 after reset until the first push.
REQ-028 Reset asserted mid-frame SHALL abandon the frame with no push and no pulse.
- Receiver accepts a new start bit from the first cycle after reset deasserts, once the synchronizer shows rx == 0.

Verification
REQ-029 Scenario: reset, out_ready=1, send 0x55 at 87 cycles/bit -> out_valid high for exactly 1 cycle with out_data=0x55; frame_err=0, overrun=0.
REQ-030 Scenario: rx low for 20 cycles, then high -> no out_valid, no frame_err; a following 0xC3 frame is received correctly.
REQ-031 Scenario: frame 0xA3 with stop bit held low 200 cycles -> frame_err one-cycle pulse, fifo_count stays 0; next frame 0x7E received correctly.
REQ-032 Scenario: out_ready=0, send 0x01..0x05 back-to-back -> fifo_count=4, overrun pulse after the 5th stop sample; with out_ready=1, pops 0x01,0x02,0x03,0x04, then out_valid=0.
REQ-033 Scenario: reset pulsed for 1 cycle during data bit 3 of 0xFF -> all outputs at reset values, no push; next frame 0x3C delivered as 0x3C.
REQ-034 Scenario: FIFO full (4 bytes), out_ready=1 in the exact cycle a 5th byte 0x99 is pushed -> no overrun, fifo_count stays 4, 0x99 popped last.
